// File: rtl/diagnostics_spi.sv
// rtl/diagnostics_spi.sv - SPI-slave diagnostics controller: halt/run, RAM read/write, VRAM dump (DIAG_VRAM_EN), config select
module diagnostics_spi #(
    parameter int ADDR_W      = 16,
    parameter int CONFIG_W    = 5,
    parameter int VRAM_AW     = 11,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                diag_spi_cs_in,
    input  logic                spi_clk_in,
    input  logic                spi_miso,
    output logic                diag_spi_out,
    output logic                halt,
    output logic [ADDR_W-1:0]   diag_ram_address,
    input  logic [7:0]          ram_dataout,
    output logic [7:0]          diag_ram_datain,
    output logic                diag_ram_we,
    output logic                diag_ram_cs,
    input  logic [CONFIG_W-1:0] configuration,
    output logic [VRAM_AW-1:0]  vram_read_address,
    input  logic [7:0]          vram_output,
    output logic                vram_read_clock,
    output logic [CONFIG_W-1:0] config_byte,
    input  logic [VRAM_AW-1:0]  vram_size
);

    typedef enum logic [3:0] {
        S_CMD, S_RD_HI, S_RD_LO, S_READ, S_WR_HI, S_WR_LO, S_WRITE,
        S_VRAM, S_SETCFG, S_GETCFG1, S_GETCFG2, S_IGNORE
    } state_t;

    state_t                 r_state, w_state_next;
    logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sck_prev;
    logic                   w_sck, w_cs_n, w_mosi, w_sck_rise, w_sck_fall, w_byte_done;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_rx_shift;
    logic [7:0]             w_rx_byte;
    logic [7:0]             r_tx_shift, r_tx_next, w_tx_next;
    logic                   r_rd_pend;
    logic                   w_set_halt, w_clr_halt, w_addr_shift, w_ram_rd, w_ram_wr, w_set_cfg;
    logic                   w_vram_start, w_vram_next, w_vram_cap;
    logic [7:0]             w_vram_data;

    assign vram_read_clock = clk;
    assign w_sck       = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise  = w_sck & ~r_sck_prev & ~w_cs_n;
    assign w_sck_fall  = ~w_sck & r_sck_prev & ~w_cs_n;
    assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
    assign w_rx_byte   = {r_rx_shift, w_mosi};

    // Bring the asynchronous SPI pins into the clk domain; data shares the clock's latency so it stays aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_clk_in};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], diag_spi_cs_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_miso};
            r_sck_prev  <= w_sck;
        end
    end

    // Receive shifter and bit counter; chip-select high drops any partial byte
    always_ff @(posedge clk) begin
        if (reset || w_cs_n) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
        end else if (w_sck_rise) begin
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_rx_shift <= {r_rx_shift[5:0], w_mosi};
        end
    end

    // Protocol state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_CMD;
        else       r_state <= w_state_next;
    end

    // Decode each completed byte into a next state, side-effect strobes and the following response byte
    always_comb begin
        w_state_next = r_state;
        w_set_halt   = 1'b0;
        w_clr_halt   = 1'b0;
        w_addr_shift = 1'b0;
        w_ram_rd     = 1'b0;
        w_ram_wr     = 1'b0;
        w_set_cfg    = 1'b0;
        w_vram_start = 1'b0;
        w_vram_next  = 1'b0;
        w_tx_next    = 8'h00;
        if (w_cs_n) begin
            w_state_next = S_CMD;
        end else if (w_byte_done) begin
            case (r_state)
                S_CMD: begin
                    case (w_rx_byte)
                        8'h01: begin w_set_halt = 1'b1; w_state_next = S_IGNORE; end
                        8'h02: begin w_clr_halt = 1'b1; w_state_next = S_IGNORE; end
                        8'h03: w_state_next = S_RD_HI;
                        8'h04: w_state_next = S_WR_HI;
`ifdef DIAG_VRAM_EN
                        8'h05: begin w_vram_start = 1'b1; w_state_next = S_VRAM; end
`endif
                        8'h06: w_state_next = S_SETCFG;
                        8'h07: begin w_tx_next = 8'(configuration); w_state_next = S_GETCFG1; end
                        default: w_state_next = S_IGNORE;
                    endcase
                end
                S_RD_HI:   begin w_addr_shift = 1'b1; w_state_next = S_RD_LO; end
                S_RD_LO:   begin w_addr_shift = 1'b1; w_ram_rd = 1'b1; w_tx_next = 8'hFF; w_state_next = S_READ; end
                S_READ:    begin w_ram_rd = 1'b1; w_tx_next = 8'hFF; end
                S_WR_HI:   begin w_addr_shift = 1'b1; w_state_next = S_WR_LO; end
                S_WR_LO:   begin w_addr_shift = 1'b1; w_state_next = S_WRITE; end
                S_WRITE:   w_ram_wr = 1'b1;
                S_VRAM:    w_vram_next = 1'b1;
                S_SETCFG:  begin w_set_cfg = 1'b1; w_state_next = S_IGNORE; end
                S_GETCFG1: begin w_tx_next = 8'(config_byte); w_state_next = S_GETCFG2; end
                S_GETCFG2: w_state_next = S_IGNORE;
                default:   w_state_next = S_IGNORE;
            endcase
        end
    end

    // Transmit shifter: a new byte is loaded on the first SCK fall after a byte boundary
    always_ff @(posedge clk) begin
        if (reset || w_cs_n) begin
            r_tx_shift   <= '0;
            diag_spi_out <= 1'b0;
        end else if (w_sck_fall) begin
            if (r_bit_cnt == 3'd0) begin
                diag_spi_out <= r_tx_next[7];
                r_tx_shift   <= {r_tx_next[6:0], 1'b0};
            end else begin
                diag_spi_out <= r_tx_shift[7];
                r_tx_shift   <= {r_tx_shift[6:0], 1'b0};
            end
        end
    end

    // Halt/config registers, single-clk RAM strobes with post-increment, and response-byte capture
    always_ff @(posedge clk) begin
        if (reset) begin
            halt             <= 1'b0;
            config_byte      <= configuration;
            diag_ram_cs      <= 1'b0;
            diag_ram_we      <= 1'b0;
            diag_ram_address <= '0;
            diag_ram_datain  <= '0;
            r_tx_next        <= '0;
            r_rd_pend        <= 1'b0;
        end else begin
            diag_ram_cs <= 1'b0;
            diag_ram_we <= 1'b0;
            r_rd_pend   <= diag_ram_cs & ~diag_ram_we;
            if (w_set_halt)      halt <= 1'b1;
            else if (w_clr_halt) halt <= 1'b0;
            if (w_set_cfg) config_byte <= w_rx_byte[CONFIG_W-1:0];
            if (w_addr_shift)     diag_ram_address <= {diag_ram_address[ADDR_W-9:0], w_rx_byte};
            else if (diag_ram_cs) diag_ram_address <= diag_ram_address + ADDR_W'(1);
            if (w_byte_done)     r_tx_next <= w_tx_next;
            else if (r_rd_pend)  r_tx_next <= ram_dataout;
            else if (w_vram_cap) r_tx_next <= w_vram_data;
            // Without halt the CPU owns the RAM: reads answer 0xFF, writes vanish
            if (halt && (w_ram_rd || w_ram_wr)) begin
                diag_ram_cs <= 1'b1;
                diag_ram_we <= w_ram_wr;
            end
            if (halt && w_ram_wr) diag_ram_datain <= w_rx_byte;
        end
    end

`ifdef DIAG_VRAM_EN
    logic [VRAM_AW-1:0] r_vram_addr;
    logic               r_vram_cap1, r_vram_cap2;

    // Address points at the next byte to send; its data is captured two clk after each byte boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vram_addr <= '0;
            r_vram_cap1 <= 1'b0;
            r_vram_cap2 <= 1'b0;
        end else begin
            r_vram_cap1 <= w_vram_start | w_vram_next;
            r_vram_cap2 <= r_vram_cap1;
            if (w_vram_start)
                r_vram_addr <= '0;
            else if (r_vram_cap2)
                r_vram_addr <= (r_vram_addr == vram_size - VRAM_AW'(1)) ? '0 : r_vram_addr + VRAM_AW'(1);
        end
    end

    assign vram_read_address = r_vram_addr;
    assign w_vram_cap        = r_vram_cap2;
    assign w_vram_data       = vram_output;
`else
    logic w_unused;
    assign vram_read_address = '0;
    assign w_vram_cap        = 1'b0;
    assign w_vram_data       = 8'h00;
    assign w_unused          = ^{vram_output, vram_size, w_vram_start, w_vram_next};
`endif

endmodule

// File: tb/tb_diagnostics_spi.sv
// tb/tb_diagnostics_spi.sv - scoreboard bench for diagnostics_spi with a byte-level reference model
`timescale 1ns/1ps
module tb_diagnostics_spi;
    localparam int HALF = 60;

    logic        clk = 1'b0;
    logic        reset, cs_n, sck, mosi;
    logic        diag_spi_out, halt, diag_ram_we, diag_ram_cs, vram_read_clock;
    logic [15:0] diag_ram_address;
    logic [7:0]  ram_dataout, diag_ram_datain, vram_output;
    logic [4:0]  configuration, config_byte;
    logic [10:0] vram_read_address, vram_size;

    always #5 clk = ~clk;

    diagnostics_spi dut (
        .clk(clk), .reset(reset), .diag_spi_cs_in(cs_n), .spi_clk_in(sck), .spi_miso(mosi),
        .diag_spi_out(diag_spi_out), .halt(halt), .diag_ram_address(diag_ram_address),
        .ram_dataout(ram_dataout), .diag_ram_datain(diag_ram_datain), .diag_ram_we(diag_ram_we),
        .diag_ram_cs(diag_ram_cs), .configuration(configuration), .vram_read_address(vram_read_address),
        .vram_output(vram_output), .vram_read_clock(vram_read_clock), .config_byte(config_byte),
        .vram_size(vram_size)
    );

    int          checks = 0;
    int          failures = 0;
    int          strobe_cnt = 0;
    logic [7:0]  mem   [0:65535];
    logic [7:0]  m_ram [0:65535];
    logic [7:0]  vmem  [0:2047];
    logic        m_halt;
    logic [4:0]  m_cfg;
    logic [7:0]  exp_q[$];
    logic [23:0] exp_wr[$];
    logic [7:0]  txb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // RAM and VRAM devices: contents randomised while reset is held
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'($urandom);
            for (int i = 0; i < 2048; i++) vmem[i] <= 8'($urandom);
        end else if (diag_ram_cs) begin
            if (diag_ram_we) mem[diag_ram_address] <= diag_ram_datain;
            else             ram_dataout <= mem[diag_ram_address];
        end
        vram_output <= vmem[vram_read_address];
    end

    // RAM bus monitor
    logic prev_cs = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            check("ram_we_qualified", {31'b0, diag_ram_we & ~diag_ram_cs}, 0);
            if (diag_ram_cs) begin
                strobe_cnt++;
                check("ram_cs_while_halted", {31'b0, halt}, 1);
                check("ram_cs_single_clk", {31'b0, prev_cs}, 0);
                if (diag_ram_we) begin
                    if (exp_wr.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL ram_write_unexpected actual=0x%0h expected=none", {diag_ram_address, diag_ram_datain});
                    end else begin
                        check("ram_write", {8'b0, diag_ram_address, diag_ram_datain}, {8'b0, exp_wr.pop_front()});
                    end
                end
            end
            prev_cs = diag_ram_cs;
        end
    end

    // MISO monitor: host samples on SCK rise
    logic [7:0] mon_byte;
    int         mon_bits = 0;
    always @(posedge sck) begin
        if (!cs_n) begin
            mon_byte = {mon_byte[6:0], diag_spi_out};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL miso_extra actual=0x%0h expected=none", mon_byte);
                end else begin
                    check("miso_byte", {24'b0, mon_byte}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end
    always @(posedge cs_n) mon_bits = 0;

    // Reference model: expected MISO stream and side effects of one complete transaction
    task automatic model_txn();
        int          n;
        logic [15:0] a;
        logic [7:0]  e, t;
        n = txb.size();
        if (n == 0) return;
        exp_q.push_back(8'h00);
        a = (n >= 3) ? {txb[1], txb[2]} : 16'h0000;
        for (int k = 1; k < n; k++) begin
            e = 8'h00;
            t = txb[k];
            case (txb[0])
                8'h03: if (k >= 3) e = m_halt ? m_ram[a + 16'(k - 3)] : 8'hFF;
                8'h04: if (k >= 3 && m_halt) begin
                    m_ram[a + 16'(k - 3)] = t;
                    exp_wr.push_back({a + 16'(k - 3), t});
                end
`ifdef DIAG_VRAM_EN
                8'h05: e = vmem[(k - 1) % int'(vram_size)];
`endif
                8'h06: if (k == 1) m_cfg = t[4:0];
                8'h07: if (k == 1) e = {3'b000, configuration};
                       else if (k == 2) e = {3'b000, m_cfg};
                default: ;
            endcase
            exp_q.push_back(e);
        end
        if (txb[0] == 8'h01) m_halt = 1'b1;
        if (txb[0] == 8'h02) m_halt = 1'b0;
    endtask

    // SPI master, mode 0, MSB first; optional trailing partial byte before CS rises
    task automatic spi_run(input int extra_bits, input logic [7:0] extra);
        logic [7:0] b;
        @(negedge clk); #2;
        cs_n = 1'b0;
        foreach (txb[i]) begin
            b = txb[i];
            for (int j = 7; j >= 0; j--) begin
                mosi = b[j]; #(HALF); sck = 1'b1; #(HALF); sck = 1'b0;
            end
        end
        for (int j = 0; j < extra_bits; j++) begin
            mosi = extra[7 - j]; #(HALF); sck = 1'b1; #(HALF); sck = 1'b0;
        end
        #(HALF);
        cs_n = 1'b1;
        mosi = 1'b0;
        #(4 * HALF);
    endtask

    task automatic txn(input int extra_bits, input logic [7:0] extra);
        model_txn();
        spi_run(extra_bits, extra);
        check("halt_state", {31'b0, halt}, {31'b0, m_halt});
        check("config_state", {27'b0, config_byte}, {27'b0, m_cfg});
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s0, nmis;
        logic [7:0]  cmd;
        reset = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        configuration = 5'h0A; vram_size = 11'd4;
        m_halt = 1'b0; m_cfg = 5'h0A;
        repeat (4) @(posedge clk);
        #1;
        check("reset_halt", {31'b0, halt}, 0);
        check("reset_spi_out", {31'b0, diag_spi_out}, 0);
        check("reset_ram_cs", {31'b0, diag_ram_cs}, 0);
        check("reset_ram_we", {31'b0, diag_ram_we}, 0);
        check("reset_ram_addr", {16'b0, diag_ram_address}, 0);
        check("reset_ram_datain", {24'b0, diag_ram_datain}, 0);
        check("reset_vram_addr", {21'b0, vram_read_address}, 0);
        check("reset_config_byte", {27'b0, config_byte}, 32'h0A);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 65536; i++) m_ram[i] = mem[i];

        txb = '{8'h01};                          txn(0, 8'h00);
        check("halt_after_01", {31'b0, halt}, 1);
        txb = '{8'h02};                          txn(0, 8'h00);
        check("halt_after_02", {31'b0, halt}, 0);
        txb = '{8'h01};                          txn(0, 8'h00);
        txb = '{8'h04, 8'h12, 8'h34, 8'hAA, 8'h55}; txn(0, 8'h00);
        check("mem_1234", {24'b0, mem[16'h1234]}, 32'hAA);
        check("mem_1235", {24'b0, mem[16'h1235]}, 32'h55);
        txb = '{8'h03, 8'h12, 8'h34, 8'h00, 8'h00}; txn(0, 8'h00);
        txb = '{8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00}; txn(0, 8'h00);
        txb = '{8'h02};                          txn(0, 8'h00);
        s0 = strobe_cnt;
        txb = '{8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00}; txn(0, 8'h00);
        txb = '{8'h04, 8'h00, 8'h10, 8'h5A};     txn(0, 8'h00);
        check("no_strobe_when_running", s0, strobe_cnt);
        txb = '{8'h06, 8'h03};                   txn(0, 8'h00);
        check("config_set_3", {27'b0, config_byte}, 3);
        txb = '{8'h07, 8'h00, 8'h00};            txn(0, 8'h00);
        vram_size = 11'd4;
        txb = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; txn(0, 8'h00);
        txb = '{};                               txn(5, 8'h01);
        txb = '{8'h07};                          txn(3, 8'hFF);
        txb = '{8'h07, 8'h00, 8'h00};            txn(0, 8'h00);

        for (int it = 0; it < 28; it++) begin
            case ($urandom_range(0, 8))
                0: cmd = 8'h01; 1: cmd = 8'h02; 2: cmd = 8'h03; 3: cmd = 8'h04;
                4: cmd = 8'h05; 5: cmd = 8'h06; 6: cmd = 8'h07; 7: cmd = 8'h01;
                default: cmd = 8'($urandom_range(8, 255));
            endcase
            txb = '{cmd};
            if (cmd == 8'h03 || cmd == 8'h04) begin
                txb.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
                txb.push_back(($urandom_range(0, 2) == 0) ? 8'hFE : 8'($urandom));
            end
            for (int j = $urandom_range(0, 4); j > 0; j--) txb.push_back(8'($urandom));
            vram_size = 11'($urandom_range(1, 6));
            txn(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0, 8'($urandom));
        end

        #1000;
        check("miso_queue_drained", exp_q.size(), 0);
        check("write_queue_drained", exp_wr.size(), 0);
        nmis = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== m_ram[i]) nmis++;
        check("ram_contents_mismatches", nmis, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
